// File: rtl/axi_common_types_pkg.sv
// Shared AXI arbitration types and sizes for the write-path slave arbiters.
// Latency: n/a (types, constants and a pointer helper only).
// Backpressure: n/a.
package axi_common_types_pkg;

    localparam int NUM_MASTERS   = 4;
    localparam int MST_IDX_WIDTH = 2;
    localparam int AXI_QOS_WIDTH = 4;

    typedef logic [MST_IDX_WIDTH-1:0] mst_idx_t;
    typedef logic [NUM_MASTERS-1:0]   mst_vec_t;

    // One write transaction walks IDLE -> ADDR -> DATA -> RESP -> IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    // Round-robin step: the index width is exactly log2(NUM_MASTERS), so the add wraps naturally.
    function automatic mst_idx_t idx_step(input mst_idx_t base, input int unsigned k);
        return base + mst_idx_t'(k);
    endfunction

endpackage

// File: rtl/rr_qos_picker.sv
// Winner selection: round robin from i_ptr, optionally restricted to the highest-QoS requesters (AXI_ARB_QOS_EN).
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the result is used.
module rr_qos_picker
    import axi_common_types_pkg::*;
(
    input  logic [NUM_MASTERS-1:0]                     i_req,
    input  logic [MST_IDX_WIDTH-1:0]                   i_ptr,
`ifdef AXI_ARB_QOS_EN
    input  logic [NUM_MASTERS-1:0][AXI_QOS_WIDTH-1:0]  i_qos,
`endif
    output logic [NUM_MASTERS-1:0]                     o_gnt,
    output logic [MST_IDX_WIDTH-1:0]                   o_idx
);

    mst_vec_t w_elig;

`ifdef AXI_ARB_QOS_EN
    logic [AXI_QOS_WIDTH-1:0] w_max_qos;

    // Highest QoS among active requesters; only those requesters stay eligible.
    always_comb begin
        w_max_qos = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (i_req[i] && (i_qos[i] > w_max_qos)) begin
                w_max_qos = i_qos[i];
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_elig[i] = i_req[i] && (i_qos[i] == w_max_qos);
        end
    end
`else
    assign w_elig = i_req;
`endif

    // First eligible master in the order ptr, ptr+1, ... (mod NUM_MASTERS).
    always_comb begin
        logic     w_found;
        mst_idx_t w_cand;
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_cand = idx_step(i_ptr, k);
            if (!w_found && w_elig[w_cand]) begin
                w_found       = 1'b1;
                o_idx         = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_slave_wr_arbiter.sv
// Single-outstanding AW/W/B write arbiter for one slave; AXI_ARB_QOS_EN adds QoS-first selection.
// Latency: grant registered 1 cycle after a request is seen in IDLE; min 1 IDLE bubble after each B.
// Backpressure: requests seen outside IDLE are held off (not dropped) until the next IDLE cycle.
module axi_slave_wr_arbiter
    import axi_common_types_pkg::*;
(
    input  logic                                       ACLK,
    input  logic                                       ARESETn,
    input  logic [NUM_MASTERS-1:0]                     m_awvalid,
    input  logic                                       s_awready,
    input  logic                                       s_wvalid,
    input  logic                                       s_wready,
    input  logic                                       s_wlast,
    input  logic                                       s_bvalid,
    input  logic                                       s_bready,
`ifdef AXI_ARB_QOS_EN
    input  logic [NUM_MASTERS-1:0][AXI_QOS_WIDTH-1:0]  m_awqos,
`endif
    output logic [NUM_MASTERS-1:0]                     gnt,
    output logic [MST_IDX_WIDTH-1:0]                   gnt_idx,
    output logic                                       aw_en,
    output logic                                       w_en,
    output logic                                       b_en
);

    arb_state_e r_state;
    arb_state_e w_next_state;
    mst_idx_t   r_ptr;
    mst_vec_t   w_pick_gnt;
    mst_idx_t   w_pick_idx;
    logic       w_aw_hs;
    logic       w_w_last_hs;
    logic       w_b_hs;

    // The AW handshake is qualified by the granted master's own AWVALID.
    assign w_aw_hs     = s_awready & m_awvalid[gnt_idx];
    assign w_w_last_hs = s_wvalid & s_wready & s_wlast;
    assign w_b_hs      = s_bvalid & s_bready;

    rr_qos_picker u_picker (
        .i_req (m_awvalid),
        .i_ptr (r_ptr),
`ifdef AXI_ARB_QOS_EN
        .i_qos (m_awqos),
`endif
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx)
    );

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and the three mutually exclusive channel enables.
    always_comb begin
        w_next_state = r_state;
        aw_en        = 1'b0;
        w_en         = 1'b0;
        b_en         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|m_awvalid) w_next_state = ADDR;
            end
            ADDR: begin
                aw_en = 1'b1;
                if (w_aw_hs) w_next_state = DATA;
            end
            DATA: begin
                w_en = 1'b1;
                if (w_w_last_hs) w_next_state = RESP;
            end
            RESP: begin
                b_en = 1'b1;
                if (w_b_hs) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Grant is loaded only from IDLE and cleared on B completion, which also advances the pointer.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            gnt     <= '0;
            gnt_idx <= '0;
            r_ptr   <= '0;
        end else if ((r_state == IDLE) && (|m_awvalid)) begin
            gnt     <= w_pick_gnt;
            gnt_idx <= w_pick_idx;
        end else if ((r_state == RESP) && w_b_hs) begin
            gnt     <= '0;
            gnt_idx <= '0;
            r_ptr   <= idx_step(gnt_idx, 1);
        end
    end

endmodule

// File: doc/axi_slave_wr_arbiter.md
AXI_SLAVE_WR_ARBITER -- requirements
Module: axi_slave_wr_arbiter

Interface
REQ-001 SHALL have port ACLK, input, 1, system clock; all state updates on posedge ACLK.
REQ-002 SHALL have port ARESETn, input, 1, reset, synchronous, active-low.
REQ-003 SHALL have port m_awvalid, input, NUM_MASTERS (4), per-master AWVALID decoded to this slave.
REQ-004 SHALL have port s_awready, input, 1, slave AWREADY.
REQ-005 SHALL have ports s_wvalid / s_wready / s_wlast, input, 1 each, W channel as seen at the slave after muxing.
REQ-006 SHALL have ports s_bvalid / s_bready, input, 1 each, B channel handshake at the slave.
REQ-007 SHALL have port gnt, output, 4, one-hot grant, registered.
REQ-008 SHALL have port gnt_idx, output, 2, binary index of gnt, registered; selects the AW/W/B muxes.
REQ-009 SHALL have port aw_en, output, 1, gate passing granted AWVALID to the slave.
REQ-010 SHALL have port w_en, output, 1, gate passing granted WVALID/WREADY.
REQ-011 SHALL have port b_en, output, 1, gate routing BVALID/BREADY to the granted master.
REQ-012 SHALL have port m_awqos, input, 4x4 bits, per-master AWQOS; present only with AXI_ARB_QOS_EN.

Function
REQ-013 SHALL implement FSM states IDLE, ADDR, DATA, RESP (enum arb_state_e).
REQ-014 IDLE: when any m_awvalid=1, SHALL pick a winner, load gnt/gnt_idx and enter ADDR at the next edge. Latency is 1 cycle from request to grant.
REQ-015 IDLE with m_awvalid=0: SHALL hold gnt=0 and all enables 0.
REQ-016 ADDR: aw_en=1. On s_awready & granted m_awvalid, SHALL go to DATA.
REQ-017 ADDR: the grant SHALL be held even if the granted m_awvalid drops, which is a protocol violation.
REQ-018 DATA: w_en=1. On s_wvalid & s_wready & s_wlast, SHALL go to RESP.
REQ-019 DATA: W beats without wlast SHALL not change state.
REQ-020 RESP: b_en=1. On s_bvalid & s_bready, SHALL go to IDLE, clear gnt and advance the priority pointer.
REQ-021 Only one of aw_en, w_en, b_en SHALL be 1 in any cycle.
REQ-022 One outstanding write only; a new grant SHALL never be issued before the B handshake completes.
REQ-023 Round robin: the pointer SHALL reset to 0. Search order is ptr, ptr+1, ... mod 4 (2-bit wrap). After a completion granted to i, ptr = (i+1) mod 4.
REQ-024 Requests arriving while not IDLE SHALL be held off, not dropped; they compete at the next IDLE cycle.
REQ-025 The IDLE->ADDR decision SHALL use only the m_awvalid values sampled on that edge.
REQ-026 The B handshake and a new request in the same cycle SHALL give IDLE for one cycle, then a new grant. This is a minimum 1-cycle bubble.

Reset
REQ-027 With ARESETn=0 at a posedge: state=IDLE, ptr=0, gnt=0, gnt_idx=0, aw_en=w_en=b_en=0, applied from that edge.
REQ-028 Reset in any state, including mid-burst, SHALL abort the transaction with no completion and no pointer advance. The outputs above SHALL hold until ARESETn=1 is sampled.

Configuration
REQ-029 Macro AXI_ARB_QOS_EN defined: m_awqos SHALL exist. IDLE SHALL grant the highest QoS among requesters, and ties SHALL resolve by the round-robin order of REQ-023.
REQ-030 Macro AXI_ARB_QOS_EN undefined: m_awqos SHALL be absent and arbitration SHALL be pure round robin.

Structure
REQ-031 axi_common_types_pkg SHALL hold NUM_MASTERS=4, MST_IDX_WIDTH=2, arb_state_e and AXI_QOS_WIDTH (existing).
REQ-032 Winner selection SHALL be a combinational sub-module rr_qos_picker (inputs: req, ptr, optional qos; outputs: one-hot, index). The FSM and pointer SHALL stay in axi_slave_wr_arbiter.

Verification
REQ-033 Reset, then m_awvalid=4'b0010 -> next cycle gnt=0010, gnt_idx=1, aw_en=1. After AW, 4-beat W and B handshakes, the pointer SHALL equal 2.
REQ-034 m_awvalid=4'b1111 held, each transaction single-beat -> grant order 0,1,2,3,0; no grant overlap; a 1-cycle IDLE bubble between each.
REQ-035 Grant to M3 completes with M0 requesting -> the pointer wraps to 0 and M0 is granted next.
REQ-036 ARESETn=0 asserted in DATA after 2 of 8 beats -> next edge state IDLE, gnt=0, w_en=0, pointer unchanged from reset value 0.
REQ-037 With AXI_ARB_QOS_EN, m_awvalid=4'b0101, qos M0=2, M2=9 -> M2 granted. With qos equal at 5, the round-robin order decides.
REQ-038 Injected s_wlast with s_wready=0 -> remain in DATA; exit only on the cycle s_wready=1.
